icache: RTL and testbench



---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_way.sv | 64 ++++++
 rtl/icache.sv | 157 +++++++++++++++
 tb/tb_icache.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache.
// The 2-way build is selected by defining ICACHE_TWO_WAY_EN.
package icache_pkg;

    localparam int unsigned InstAddrBus       = 32;
    localparam int unsigned InstBus           = 32;
    localparam logic [InstBus-1:0] ZeroWord   = '0;
    localparam int unsigned ICACHE_INDEX_BITS = 7;
    localparam int unsigned ICACHE_TAG_BITS   = 8;

`ifdef ICACHE_TWO_WAY_EN
    localparam int unsigned ICACHE_WAYS = 2;
`else
    localparam int unsigned ICACHE_WAYS = 1;
`endif

endpackage

// File: rtl/icache_way.sv
// One cache way: valid flops, tag and data arrays, two async read ports, sync write.
// Reset and flush clear only the valid bits; precedence is rst > flush_i > we_i.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned IndexBits = ICACHE_INDEX_BITS,
    parameter int unsigned TagBits   = ICACHE_TAG_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 we_i,
    input  logic [IndexBits-1:0] widx_i,
    input  logic [TagBits-1:0]   wtag_i,
    input  logic [InstBus-1:0]   wdata_i,
    input  logic [IndexBits-1:0] ridx_i,
    output logic                 rvalid_o,
    output logic [TagBits-1:0]   rtag_o,
    output logic [InstBus-1:0]   rdata_o,
    output logic                 wvalid_o,
    output logic [TagBits-1:0]   wtag_o
);

    localparam int unsigned Sets = 2 ** IndexBits;

    logic [Sets-1:0]    valid_q, valid_d;
    logic [TagBits-1:0] tag_q  [Sets];
    logic [InstBus-1:0] data_q [Sets];
    logic               wr_en;

    assign wr_en = we_i & ~flush_i & ~rst;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[widx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];
    assign wvalid_o = valid_q[widx_i];
    assign wtag_o   = tag_q[widx_i];

endmodule

// File: rtl/icache.sv
// Instruction cache top: tag compare, fill way / LRU selection, hit/miss counters.
// Direct-mapped by default; 2-way set-associative when ICACHE_TWO_WAY_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int unsigned TAG_BITS   = ICACHE_TAG_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_i,
    input  logic [InstAddrBus-1:0] read_addr_i,
    input  logic                   write_i,
    input  logic [InstAddrBus-1:0] write_addr_i,
    input  logic [InstBus-1:0]     write_inst_i,
    input  logic                   flush_i,
    output logic                   read_hit_o,
    output logic [InstBus-1:0]     read_inst_o,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o
);

    localparam int unsigned Ways = ICACHE_WAYS;
    localparam int unsigned Hi   = TAG_BITS + INDEX_BITS + 1;

    logic [INDEX_BITS-1:0] ridx, widx;
    logic [TAG_BITS-1:0]   rtag, wtag;
    logic                  fill;

    assign ridx = read_addr_i[INDEX_BITS+1:2];
    assign rtag = read_addr_i[Hi:INDEX_BITS+2];
    assign widx = write_addr_i[INDEX_BITS+1:2];
    assign wtag = write_addr_i[Hi:INDEX_BITS+2];
    assign fill = write_i & ~flush_i;

    logic unused_addr;
    assign unused_addr = ^{read_addr_i[InstAddrBus-1:Hi+1], read_addr_i[1:0],
                           write_addr_i[InstAddrBus-1:Hi+1], write_addr_i[1:0]};

    logic [Ways-1:0]     rvalid, wvalid, way_we, way_hit;
    logic [TAG_BITS-1:0] rtag_w [Ways];
    logic [TAG_BITS-1:0] wtag_w [Ways];
    logic [InstBus-1:0]  rdata_w [Ways];

    for (genvar w = 0; w < Ways; w++) begin : g_way
        icache_way #(
            .IndexBits (INDEX_BITS),
            .TagBits   (TAG_BITS)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .flush_i  (flush_i),
            .we_i     (way_we[w]),
            .widx_i   (widx),
            .wtag_i   (wtag),
            .wdata_i  (write_inst_i),
            .ridx_i   (ridx),
            .rvalid_o (rvalid[w]),
            .rtag_o   (rtag_w[w]),
            .rdata_o  (rdata_w[w]),
            .wvalid_o (wvalid[w]),
            .wtag_o   (wtag_w[w])
        );
        assign way_hit[w] = rvalid[w] & (rtag_w[w] == rtag);
    end

    assign read_hit_o = read_i & (|way_hit);

    always_comb begin
        read_inst_o = ZeroWord;
        for (int w = 0; w < Ways; w++) begin
            if (read_i && way_hit[w]) begin
                read_inst_o = rdata_w[w];
            end
        end
    end

`ifdef ICACHE_TWO_WAY_EN
    localparam int unsigned Sets = 2 ** INDEX_BITS;

    logic [Sets-1:0] lru_q, lru_d;
    logic [1:0]      wmatch;
    logic            fill_way;

    assign wmatch[0] = wvalid[0] & (wtag_w[0] == wtag);
    assign wmatch[1] = wvalid[1] & (wtag_w[1] == wtag);

    always_comb begin
        if (wmatch[0]) begin
            fill_way = 1'b0;
        end else if (wmatch[1]) begin
            fill_way = 1'b1;
        end else if (!wvalid[0]) begin
            fill_way = 1'b0;
        end else if (!wvalid[1]) begin
            fill_way = 1'b1;
        end else begin
            fill_way = lru_q[widx];
        end
    end

    assign way_we[0] = fill & ~fill_way;
    assign way_we[1] = fill & fill_way;

    // LRU points at the way not just used; a fill overrides a hit on the same set.
    always_comb begin
        lru_d = lru_q;
        if (read_hit_o) begin
            lru_d[ridx] = way_hit[0];
        end
        if (fill) begin
            lru_d[widx] = ~fill_way;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end
`else
    assign way_we[0] = fill;

    logic unused_fill;
    assign unused_fill = ^{wvalid, wtag_w[0]};
`endif

    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (read_i) begin
            if (read_hit_o) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand sequences, random vs model.
module tb_icache;

`ifdef ICACHE_TWO_WAY_EN
    localparam bit TwoWay = 1'b1;
`else
    localparam bit TwoWay = 1'b0;
`endif
    localparam int NWays = TwoWay ? 2 : 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_i, write_i, flush_i;
    logic [31:0] read_addr_i, write_addr_i, write_inst_i;
    logic        read_hit_o;
    logic [31:0] read_inst_o, hit_cnt_o, miss_cnt_o;

    icache dut (
        .clk          (clk),
        .rst          (rst),
        .read_i       (read_i),
        .read_addr_i  (read_addr_i),
        .write_i      (write_i),
        .write_addr_i (write_addr_i),
        .write_inst_i (write_inst_i),
        .flush_i      (flush_i),
        .read_hit_o   (read_hit_o),
        .read_inst_o  (read_inst_o),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: each set is a small list of (valid, tag, word) entries plus an LRU pointer.
    bit          mv   [2][128];
    logic [7:0]  mtag [2][128];
    logic [31:0] mdat [2][128];
    bit          mlru [128];
    logic [31:0] mhit, mmiss;

    function automatic void m_lookup(input logic [31:0] a, output bit h, output int way,
                                     output logic [31:0] d);
        int idx = int'(a[8:2]);
        h = 0; way = 0; d = 32'h0;
        for (int w = 0; w < NWays; w++) begin
            if (mv[w][idx] && mtag[w][idx] == a[16:9]) begin
                h = 1; way = w; d = mdat[w][idx];
            end
        end
    endfunction

    function automatic void m_reset();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 128; i++) mv[w][i] = 0;
        for (int i = 0; i < 128; i++) mlru[i] = 0;
        mhit = 0; mmiss = 0;
    endfunction

    function automatic void m_edge();
        bit h; int hw; logic [31:0] d;
        int widx = int'(write_addr_i[8:2]);
        int fw;
        bit found;
        if (rst) begin
            m_reset();
            return;
        end
        // Fill way from pre-edge state: existing tag, then first invalid, then LRU.
        found = 0; fw = 0;
        for (int w = 0; w < NWays; w++)
            if (!found && mv[w][widx] && mtag[w][widx] == write_addr_i[16:9]) begin
                found = 1; fw = w;
            end
        for (int w = 0; w < NWays; w++)
            if (!found && !mv[w][widx]) begin
                found = 1; fw = w;
            end
        if (!found) fw = int'(mlru[widx]);
        m_lookup(read_addr_i, h, hw, d);
        if (read_i) begin
            if (h) begin
                mhit++;
                if (TwoWay) mlru[int'(read_addr_i[8:2])] = (hw == 0);
            end else begin
                mmiss++;
            end
        end
        if (flush_i) begin
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < 128; i++) mv[w][i] = 0;
        end else if (write_i) begin
            mv[fw][widx]   = 1;
            mtag[fw][widx] = write_addr_i[16:9];
            mdat[fw][widx] = write_inst_i;
            if (TwoWay) mlru[widx] = (fw == 0);
        end
    endfunction

    // Drives one cycle; checks outputs against explicit values (use_exp) or the model.
    task automatic cycle(input string name, input bit r_rst, input bit r, input logic [31:0] ra,
                         input bit w, input logic [31:0] wa, input logic [31:0] wd, input bit f,
                         input bit use_exp, input bit eh, input logic [31:0] ei);
        bit mh; int mw; logic [31:0] md;
        rst = r_rst; read_i = r; read_addr_i = ra;
        write_i = w; write_addr_i = wa; write_inst_i = wd; flush_i = f;
        #1;
        m_lookup(ra, mh, mw, md);
        if (use_exp) begin
            chk({name, ".hit"}, {31'b0, read_hit_o}, {31'b0, eh});
            chk({name, ".inst"}, read_inst_o, eh ? ei : 32'h0);
        end else begin
            chk({name, ".hit"}, {31'b0, read_hit_o}, {31'b0, r & mh});
            chk({name, ".inst"}, read_inst_o, (r & mh) ? md : 32'h0);
        end
        chk({name, ".hitcnt"}, hit_cnt_o, mhit);
        chk({name, ".misscnt"}, miss_cnt_o, mmiss);
        @(posedge clk);
        m_edge();
        #1;
        rst = 0; read_i = 0; write_i = 0; flush_i = 0;
    endtask

    typedef struct {
        bit          r;
        logic [31:0] ra;
        bit          w;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          f;
        bit          eh;
        logic [31:0] ei;
    } vec_t;

    vec_t vec [18];

    initial begin
        rst = 1; read_i = 0; write_i = 0; flush_i = 0;
        read_addr_i = 0; write_addr_i = 0; write_inst_i = 0;
        m_reset();

        vec[0]  = '{1, 32'h000, 0, 32'h000, 32'h0,        0, 0, 32'h0};
        vec[1]  = '{0, 32'h000, 1, 32'h004, 32'h00A00093, 0, 0, 32'h0};
        vec[2]  = '{1, 32'h004, 0, 32'h000, 32'h0,        0, 1, 32'h00A00093};
        vec[3]  = '{1, 32'h008, 1, 32'h008, 32'h00100113, 0, 0, 32'h0};
        vec[4]  = '{1, 32'h008, 0, 32'h000, 32'h0,        0, 1, 32'h00100113};
        vec[5]  = '{0, 32'h000, 1, 32'h204, 32'h00200193, 0, 0, 32'h0};
        vec[6]  = '{1, 32'h004, 0, 32'h000, 32'h0,        0, TwoWay, 32'h00A00093};
        vec[7]  = '{1, 32'h204, 0, 32'h000, 32'h0,        0, 1, 32'h00200193};
        vec[8]  = '{0, 32'h000, 1, 32'h00C, 32'hDEADBEEF, 1, 0, 32'h0};
        vec[9]  = '{1, 32'h204, 0, 32'h000, 32'h0,        0, 0, 32'h0};
        vec[10] = '{1, 32'h00C, 0, 32'h000, 32'h0,        0, 0, 32'h0};
        vec[11] = '{0, 32'h000, 1, 32'h004, 32'h00A00093, 0, 0, 32'h0};
        vec[12] = '{0, 32'h000, 1, 32'h204, 32'h00200193, 0, 0, 32'h0};
        vec[13] = '{1, 32'h004, 0, 32'h000, 32'h0,        0, TwoWay, 32'h00A00093};
        vec[14] = '{0, 32'h000, 1, 32'h404, 32'h00300213, 0, 0, 32'h0};
        vec[15] = '{1, 32'h204, 0, 32'h000, 32'h0,        0, 0, 32'h0};
        vec[16] = '{1, 32'h004, 0, 32'h000, 32'h0,        0, TwoWay, 32'h00A00093};
        vec[17] = '{1, 32'h404, 0, 32'h000, 32'h0,        0, 1, 32'h00300213};

        @(posedge clk);
        m_edge();
        #1;
        rst = 0;
        chk("reset.hitcnt", hit_cnt_o, 32'd0);
        chk("reset.misscnt", miss_cnt_o, 32'd0);

        for (int i = 0; i < 18; i++) begin
            cycle($sformatf("vec%0d", i), 0, vec[i].r, vec[i].ra, vec[i].w, vec[i].wa,
                  vec[i].wd, vec[i].f, 1, vec[i].eh, vec[i].ei);
            if (i == 0) chk("first_miss.misscnt", miss_cnt_o, 32'd1);
            if (i == 2) chk("first_hit.hitcnt", hit_cnt_o, 32'd1);
            if (i == 8) begin
                chk("flush.hitcnt", hit_cnt_o, TwoWay ? 32'd4 : 32'd3);
                chk("flush.misscnt", miss_cnt_o, TwoWay ? 32'd2 : 32'd3);
            end
        end
        chk("table.hitcnt", hit_cnt_o, TwoWay ? 32'd7 : 32'd4);
        chk("table.misscnt", miss_cnt_o, TwoWay ? 32'd5 : 32'd8);

        // Reset with a concurrent fill: fill dropped, counters and lines cleared.
        cycle("rst_fill", 1, 1, 32'h404, 1, 32'h010, 32'h12345678, 0, 1, 1, 32'h00300213);
        cycle("after_rst_a", 0, 1, 32'h010, 0, 0, 0, 0, 1, 0, 32'h0);
        cycle("after_rst_b", 0, 1, 32'h404, 0, 0, 0, 0, 1, 0, 32'h0);
        chk("after_rst.misscnt", miss_cnt_o, 32'd2);
        chk("after_rst.hitcnt", hit_cnt_o, 32'd0);

        // High address bits above the tag field are ignored.
        cycle("hi_fill", 0, 0, 0, 1, 32'hFFFE_0204, 32'hCAFEF00D, 0, 1, 0, 32'h0);
        cycle("hi_read", 0, 1, 32'h0000_0207, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, wa;
            ra = $urandom; wa = $urandom;
            ra[8:4] = 5'h0; ra[16:11] = 6'h0;
            wa[8:4] = 5'h0; wa[16:11] = 6'h0;
            cycle($sformatf("rnd%0d", n), ($urandom_range(99) == 0), $urandom_range(1) == 1,
                  ra, $urandom_range(2) == 0, wa, $urandom, $urandom_range(29) == 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
